mem_copy_master: RTL and testbench

MEM_COPY_MASTER -- requirements
Module: mem_copy_master

---
 rtl/mem_copy_master.sv | 115 +++++++++++
 tb/tb_mem_copy_master.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_master.sv
// Avalon-MM word copy engine: read one word, write it back out, repeat in
// ascending address order, keeping a running XOR checksum of the copied data.
module mem_copy_master #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [ADDR_W:0]     length,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   checksum,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_chipselect,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest,
  output logic [2:0]          dbg_state
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD      = 3'd1;
  localparam logic [2:0] RD_DATA = 3'd2;
  localparam logic [2:0] WR      = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] csum_q, csum_d;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    csum_d  = csum_q;
    case (state_q)
      IDLE: begin
        // A zero-length start still counts as a job, so it clears the checksum.
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          cnt_d   = length;
          csum_d  = '0;
          state_d = (length == '0) ? DONE : RD;
        end
      end
      RD: begin
        if (!avm_waitrequest) state_d = RD_DATA;
      end
      RD_DATA: begin
        hold_d  = avm_readdata;
        csum_d  = csum_q ^ avm_readdata;
        state_d = WR;
      end
      WR: begin
        if (!avm_waitrequest) begin
          src_d   = src_q + 1'b1;
          dst_d   = dst_q + 1'b1;
          cnt_d   = cnt_q - 1'b1;
          state_d = (cnt_q == CNT_ONE) ? DONE : RD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      csum_q  <= csum_d;
    end
  end

  // Bus outputs decode straight from registered state, so they stay frozen
  // for as long as waitrequest holds the FSM in RD or WR.
  always_comb begin
    avm_read       = (state_q == RD);
    avm_write      = (state_q == WR);
    avm_chipselect = avm_read | avm_write;
    avm_byteenable = {(DATA_W/8){avm_chipselect}};
    avm_address    = avm_read ? src_q : (avm_write ? dst_q : '0);
    avm_writedata  = avm_write ? hold_q : '0;
  end

  assign busy      = (state_q == RD) || (state_q == RD_DATA) || (state_q == WR);
  assign done      = (state_q == DONE);
  assign checksum  = csum_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_copy_master.sv
// Bench for mem_copy_master: Avalon slave memory, reference copy model and
// a transfer-by-transfer scoreboard with done/checksum/latency checks.
module tb_mem_copy_master;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MEM_N = 1 << AW;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;
  logic [AW-1:0] avm_address;
  logic          avm_chipselect;
  logic          avm_read;
  logic          avm_write;
  logic [3:0]    avm_byteenable;
  logic [DW-1:0] avm_writedata;
  logic [DW-1:0] avm_readdata;
  logic          avm_waitrequest;
  logic [2:0]    dbg_state;

  mem_copy_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy), .done(done), .checksum(checksum),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // expected transfer: {is_write, address, data (0 for reads)}
  logic [AW+DW:0] exp_q[$];
  // expected completion: {check_latency, start_cycle, length, checksum}
  typedef struct {
    logic          chk_lat;
    int            start_cyc;
    int            len;
    logic [DW-1:0] csum;
  } done_t;
  done_t done_q[$];

  logic [DW-1:0] mem[MEM_N];
  logic [DW-1:0] ref_mem[MEM_N];
  logic          wait_en;
  logic [DW-1:0] last_csum;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // slave memory + monitor, all evaluated mid-cycle
  logic          rd_pend;
  logic [DW-1:0] rd_val;
  logic          prev_wait_req;
  logic [AW+DW+6:0] prev_bus;

  always @(negedge clk) begin
    if (!reset_n) begin
      rd_pend = 1'b0;
      prev_wait_req = 1'b0;
      avm_waitrequest = 1'b0;
    end else begin
      avm_readdata = rd_pend ? rd_val : $urandom;
      if (prev_wait_req)
        check("bus_stable_during_wait",
              64'({avm_read, avm_write, avm_chipselect, avm_byteenable, avm_address, avm_writedata}),
              64'(prev_bus));
      avm_waitrequest = wait_en ? 1'($urandom_range(0, 1)) : 1'b0;
      check("chipselect_rule", 64'({avm_chipselect, avm_read & avm_write}),
            64'({avm_read | avm_write, 1'b0}));
      check("byteenable", 64'(avm_byteenable), avm_chipselect ? 64'hF : 64'h0);
      rd_pend = 1'b0;
      if (avm_chipselect && !avm_waitrequest) begin
        if (exp_q.size() == 0) begin
          check("unexpected_transfer", 64'({avm_write, avm_address}), 64'h0);
        end else begin
          logic [AW+DW:0] e;
          e = exp_q.pop_front();
          check(avm_write ? "write_xfer" : "read_xfer",
                64'({avm_write, avm_address, avm_write ? avm_writedata : 32'h0}), 64'(e));
        end
        if (avm_read) begin
          rd_pend = 1'b1;
          rd_val  = mem[avm_address];
        end else if (avm_write) begin
          mem[avm_address] = avm_writedata;
        end
      end
      prev_wait_req = avm_chipselect && avm_waitrequest;
      prev_bus = {avm_read, avm_write, avm_chipselect, avm_byteenable, avm_address, avm_writedata};
      if (done) begin
        if (done_q.size() == 0) begin
          check("spurious_done", 64'(done), 64'h0);
        end else begin
          done_t d;
          d = done_q.pop_front();
          check("checksum_at_done", 64'(checksum), 64'(d.csum));
          check("busy_low_at_done", 64'(busy), 64'h0);
          check("transfers_complete_at_done", 64'(exp_q.size()), 64'h0);
          if (d.chk_lat)
            check("done_latency", 64'(cyc - d.start_cyc), 64'(3 * d.len + 1));
        end
      end
    end
  end

  // driver: call just after a falling edge; model computes the expected bus trace
  task automatic start_job(input logic [AW-1:0] s, input logic [AW-1:0] d,
                           input int len, input logic chk_lat);
    done_t dn;
    logic [DW-1:0] cs;
    cs = '0;
    for (int i = 0; i < len; i++) begin
      int sa;
      int da;
      logic [DW-1:0] v;
      sa = (int'(s) + i) % MEM_N;
      da = (int'(d) + i) % MEM_N;
      v  = ref_mem[sa];
      exp_q.push_back({1'b0, AW'(sa), 32'h0});
      exp_q.push_back({1'b1, AW'(da), v});
      ref_mem[da] = v;
      cs = cs ^ v;
    end
    dn.chk_lat = chk_lat;
    dn.start_cyc = cyc;
    dn.len = len;
    dn.csum = cs;
    done_q.push_back(dn);
    last_csum = cs;
    src_addr = s;
    dst_addr = d;
    length = (AW+1)'(len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    src_addr = AW'($urandom);
    dst_addr = AW'($urandom);
    length = (AW+1)'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (done_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (done_q.size() != 0) begin
      check("job_timeout", 64'(done_q.size()), 64'h0);
      done_q.delete();
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, 64'({busy, done, avm_read, avm_write, avm_chipselect, avm_byteenable,
                     avm_address, dbg_state}), 64'h0);
    check({name, "_data"}, 64'({checksum, avm_writedata}), 64'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    length = '0;
    wait_en = 1'b0;
    avm_readdata = '0;
    avm_waitrequest = 1'b0;
    last_csum = '0;
    for (int i = 0; i < MEM_N; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[16 + i] = 32'(i + 1);
    for (int i = 0; i < MEM_N; i++) ref_mem[i] = mem[i];

    repeat (3) @(negedge clk);
    check_reset_outputs("reset_values");
    reset_n = 1'b1;
    // start on the very first edge after release
    start_job(10'h010, 10'h100, 4, 1'b1);
    wait_idle();
    for (int i = 0; i < 4; i++) check("copy4_mem", 64'(mem[10'h100 + i]), 64'(i + 1));
    check("copy4_checksum", 64'(checksum), 64'h4);
    repeat (4) @(negedge clk);
    check("checksum_held", 64'(checksum), 64'(last_csum));

    start_job(10'h000, 10'h000, 0, 1'b1);
    wait_idle();
    check("len0_checksum", 64'(checksum), 64'h0);

    start_job(10'h3FE, 10'h3FF, 3, 1'b1);
    wait_idle();

    wait_en = 1'b1;
    start_job(AW'($urandom), AW'($urandom), 16, 1'b0);
    wait_idle();

    for (int j = 0; j < 6; j++) begin
      wait_en = 1'($urandom_range(0, 1));
      start_job(AW'($urandom), AW'($urandom), $urandom_range(1, 8), ~wait_en);
      wait_idle();
    end

    // start pulses while busy must change nothing
    wait_en = 1'b0;
    start_job(10'h200, 10'h204, 8, 1'b1);
    repeat (4) @(negedge clk);
    src_addr = 10'h055;
    dst_addr = 10'h066;
    length = 11'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("idle_after_ignored_start", 64'({busy, done, avm_chipselect}), 64'h0);

    // reset mid-job abandons it
    start_job(10'h300, 10'h340, 16, 1'b0);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midjob_reset_values");
    exp_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < MEM_N; i++) ref_mem[i] = mem[i];
    repeat (20) @(negedge clk);
    check("quiet_after_reset", 64'({busy, done, avm_chipselect}), 64'h0);

    start_job(AW'($urandom), AW'($urandom), 5, 1'b1);
    wait_idle();
    for (int i = 0; i < MEM_N; i++)
      if (mem[i] !== ref_mem[i]) check("final_mem", 64'(mem[i]), 64'(ref_mem[i]));
    checks++;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
